// File: rtl/aes_byte_loader.sv
// Byte-serial key/plaintext loader for the AES-128 core: packs 32 bytes into a 4-beat load burst.
// Optional inter-byte idle timeout is compiled in with `define AES_LOADER_TIMEOUT_EN.
module aes_byte_loader #(
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid_in,
  input  logic              core_dv_in,
  input  logic              clr_err_in,
  output logic              ready_out,
  output logic [31:0]       key_out,
  output logic [31:0]       plaintext_out,
  output logic              mp_dv_out,
  output logic              busy_out,
  output logic              overflow_err,
  output logic              timeout_err
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StFill, StIssue, StWait, StGap} state_e;

  state_e       r_state, w_state_next;
  logic [4:0]   r_byte_cnt, w_byte_cnt_next;
  logic [255:0] r_buf, w_buf_next;
  logic [1:0]   r_beat, w_beat_next;
  logic [2:0]   r_dv_cnt, w_dv_cnt_next;
  logic         r_ready, r_ovf, r_tmo;
  logic         w_accept, w_expire, w_tmo_set;
  logic [31:0]  w_key_word, w_pt_word;

  // Ready is registered so it stays low while in reset and rises one edge after release.
  assign w_accept = byte_valid_in & r_ready;

`ifdef AES_LOADER_TIMEOUT_EN
  logic [15:0] r_idle;

  assign w_expire = (r_state == StFill) && (r_byte_cnt != 5'd0) && !w_accept &&
                    (r_idle == TimeoutLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= 16'd0;
    end else if ((r_state != StFill) || (r_byte_cnt == 5'd0) || w_accept || w_expire) begin
      r_idle <= 16'd0;
    end else begin
      r_idle <= r_idle + 16'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = ^TimeoutLast;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_buf_next      = r_buf;
    w_beat_next     = r_beat;
    w_dv_cnt_next   = r_dv_cnt;
    w_tmo_set       = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_accept) begin
          // Shifting in at the bottom leaves byte k at bits [255-8k -: 8] after 32 bytes.
          w_buf_next = {r_buf[247:0], byte_in[7:0]};
          if (r_byte_cnt == 5'd31) begin
            w_state_next    = StIssue;
            w_byte_cnt_next = 5'd0;
          end else begin
            w_byte_cnt_next = r_byte_cnt + 5'd1;
          end
        end else if (w_expire) begin
          w_byte_cnt_next = 5'd0;
          w_tmo_set       = 1'b1;
        end
      end
      StIssue: begin
        w_beat_next = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (core_dv_in) begin
          if (r_dv_cnt == 3'd3) begin
            w_state_next  = StGap;
            w_dv_cnt_next = 3'd0;
          end else begin
            w_dv_cnt_next = r_dv_cnt + 3'd1;
          end
        end
      end
      StGap: begin
        w_state_next    = StFill;
        w_byte_cnt_next = 5'd0;
      end
      default: w_state_next = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StFill;
      r_byte_cnt <= 5'd0;
      r_buf      <= 256'd0;
      r_beat     <= 2'd0;
      r_dv_cnt   <= 3'd0;
      r_ready    <= 1'b0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_buf      <= w_buf_next;
      r_beat     <= w_beat_next;
      r_dv_cnt   <= w_dv_cnt_next;
      r_ready    <= (w_state_next == StFill);
      if (byte_valid_in && !r_ready) begin
        r_ovf <= 1'b1;
      end else if (clr_err_in) begin
        r_ovf <= 1'b0;
      end
      if (w_tmo_set) begin
        r_tmo <= 1'b1;
      end else if (clr_err_in) begin
        r_tmo <= 1'b0;
      end
    end
  end

  always_comb begin
    w_key_word = 32'd0;
    w_pt_word  = 32'd0;
    unique case (r_beat)
      2'd0: begin w_key_word = r_buf[255:224]; w_pt_word = r_buf[127:96]; end
      2'd1: begin w_key_word = r_buf[223:192]; w_pt_word = r_buf[95:64];  end
      2'd2: begin w_key_word = r_buf[191:160]; w_pt_word = r_buf[63:32];  end
      2'd3: begin w_key_word = r_buf[159:128]; w_pt_word = r_buf[31:0];   end
      default: begin w_key_word = 32'd0; w_pt_word = 32'd0; end
    endcase
  end

  assign mp_dv_out     = (r_state == StIssue);
  assign key_out       = mp_dv_out ? w_key_word : 32'd0;
  assign plaintext_out = mp_dv_out ? w_pt_word : 32'd0;
  assign busy_out      = (r_state != StFill);
  assign ready_out     = r_ready;
  assign overflow_err  = r_ovf;
  assign timeout_err   = r_tmo;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Randomized scoreboard bench for aes_byte_loader; expected load beats come from a byte-list model.
module tb_aes_byte_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid_in = 1'b0;
  logic        core_dv_in = 1'b0;
  logic        clr_err_in = 1'b0;
  logic        ready_out, mp_dv_out, busy_out, overflow_err, timeout_err;
  logic [31:0] key_out, plaintext_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  blk[$];
  logic [7:0]  fips[32];

  aes_byte_loader #(
    .BYTE_W        (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid_in(byte_valid_in),
    .core_dv_in   (core_dv_in),
    .clr_err_in   (clr_err_in),
    .ready_out    (ready_out),
    .key_out      (key_out),
    .plaintext_out(plaintext_out),
    .mp_dv_out    (mp_dv_out),
    .busy_out     (busy_out),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every 32 accepted bytes become 4 beats of {key word, plaintext word}, MSB-first.
  task automatic model_push(input logic [7:0] b);
    blk.push_back(b);
    if (blk.size() == 32) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back({blk[4*j], blk[4*j+1], blk[4*j+2], blk[4*j+3],
                         blk[16+4*j], blk[17+4*j], blk[18+4*j], blk[19+4*j]});
      end
      blk.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mp_dv_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(mp_dv_out), 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("key_word", key_out, e[63:32]);
          check("pt_word", plaintext_out, e[31:0]);
        end
      end else begin
        check("key_idle_zero", key_out, 32'd0);
        check("pt_idle_zero", plaintext_out, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    t = 0;
    while (!ready_out && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_out) begin
      check("ready_wait_timeout", 32'(ready_out), 32'd1);
      return;
    end
    byte_in       = b;
    byte_valid_in = 1'b1;
    @(negedge clk);
    byte_valid_in = 1'b0;
    model_push(b);
  endtask

  task automatic send_fips(input int gmin, input int gmax);
    for (int i = 0; i < 32; i++) send_byte(fips[i], (gmax == 0) ? 0 : $urandom_range(gmax, gmin));
  endtask

  task automatic send_random(input int gmax);
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), $urandom_range(gmax, 0));
  endtask

  // Called right after the 32nd byte: expects 4 strobe cycles; core_dv_in held high is ignored.
  task automatic issue_check();
    core_dv_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mp_dv_beat", 32'(mp_dv_out), 32'd1);
      check("ready_low_issue", 32'(ready_out), 32'd0);
      @(negedge clk);
    end
    core_dv_in = 1'b0;
    check("mp_dv_after_4", 32'(mp_dv_out), 32'd0);
    check("busy_in_wait", 32'(busy_out), 32'd1);
  endtask

  task automatic core_burst(input int stall);
    repeat (stall) @(negedge clk);
    check("busy_after_stall", 32'(busy_out), 32'd1);
    for (int i = 0; i < 4; i++) begin
      core_dv_in = 1'b1;
      @(negedge clk);
      core_dv_in = 1'b0;
      check("busy_during_burst", 32'(busy_out), 32'd1);
      check("ready_during_burst", 32'(ready_out), 32'd0);
      if (i < 3) repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    @(negedge clk);
    check("ready_after_gap", 32'(ready_out), 32'd1);
    check("busy_after_gap", 32'(busy_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) fips[i] = 8'(i);
    for (int i = 0; i < 16; i++) fips[16+i] = 8'(i * 17);

    #1;
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_mp_dv", 32'(mp_dv_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_key", key_out, 32'd0);
    check("rst_pt", plaintext_out, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_first_edge", 32'(ready_out), 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", 32'(ready_out), 32'd1);

    // FIPS-197 C.1 back-to-back, long core stall
    send_fips(0, 0);
    issue_check();
    core_burst(20);

    // Overflow during WAIT, then set-wins-over-clear, then clear
    send_random(0);
    issue_check();
    byte_in       = 8'($urandom);
    byte_valid_in = 1'b1;
    @(negedge clk);
    byte_valid_in = 1'b0;
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("ovf_state_kept", 32'(busy_out), 32'd1);
    clr_err_in    = 1'b1;
    byte_valid_in = 1'b1;
    @(negedge clk);
    clr_err_in    = 1'b0;
    byte_valid_in = 1'b0;
    check("ovf_set_wins", 32'(overflow_err), 32'd1);
    core_burst(3);
    send_fips(1, 7);
    issue_check();
    core_burst(2);
    clr_err_in = 1'b1;
    @(negedge clk);
    clr_err_in = 1'b0;
    check("ovf_cleared", 32'(overflow_err), 32'd0);

    // Reset asserted on beat 2
    send_random(2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mp_dv", 32'(mp_dv_out), 32'd0);
    check("rst_mid_busy", 32'(busy_out), 32'd0);
    check("rst_mid_key", key_out, 32'd0);
    exp_q.delete();
    blk.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_random(0);
    issue_check();
    core_burst(1);

    for (int k = 0; k < 4; k++) begin
      send_random(3);
      issue_check();
      core_burst($urandom_range(5, 0));
    end

`ifdef AES_LOADER_TIMEOUT_EN
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    repeat (15) @(negedge clk);
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("tmo_set", 32'(timeout_err), 32'd1);
    blk.delete();
    clr_err_in = 1'b1;
    @(negedge clk);
    clr_err_in = 1'b0;
    check("tmo_cleared", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 15);
    check("tmo_cancelled", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 21; i++) send_byte(8'($urandom), 0);
    issue_check();
    core_burst(2);
`endif

    check("tmo_final", 32'(timeout_err), 32'd0);
    check("ovf_final", 32'(overflow_err), 32'd0);
    check("beats_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
